// File: rtl/sfifo_ram_pf_gen.sv
// First-word-fall-through FIFO: inferred simple-dual-port RAM with RD_LAT read latency,
// drained by a credit-managed register prefetch buffer so dout is valid whenever empty=0.
module sfifo_ram_pf_gen #(
  parameter int WIDTH       = 64,
  parameter int DEPTH_NBITS = 12,
  parameter int DEPTH       = 1 << DEPTH_NBITS,
  parameter int RD_LAT      = 1,
  parameter int PF_DEPTH    = RD_LAT + 1,
  parameter int AF_THRESH   = DEPTH - 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  input  logic                   wr,
  input  logic                   rd,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic                   afull,
  output logic [DEPTH_NBITS:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int CW    = DEPTH_NBITS + 1;
  localparam int PF_AW = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
  localparam int PF_CW = $clog2(PF_DEPTH + 1);

  localparam logic [CW-1:0]          DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]          AF_C     = CW'(AF_THRESH);
  localparam logic [DEPTH_NBITS-1:0] RAM_LAST = DEPTH_NBITS'(DEPTH - 1);
  localparam logic [PF_AW-1:0]       PF_LAST  = PF_AW'(PF_DEPTH - 1);
  localparam logic [PF_CW-1:0]       PF_FULL  = PF_CW'(PF_DEPTH);

  // Handshake: wr is accepted when wr_ok=1 (not full, or full with a same-cycle pop);
  // rd pops the word on dout when rd_ok=1 (empty=0). Rejected requests only set sticky flags.

  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          ram_cnt_q, ram_cnt_d;
  logic [DEPTH_NBITS-1:0] wptr_q, wptr_d;
  logic [DEPTH_NBITS-1:0] rptr_q, rptr_d;
  logic [RD_LAT-1:0]      vld_q, vld_d;
  logic [PF_CW-1:0]       pf_cnt_q, pf_cnt_d;
  logic [PF_AW-1:0]       pf_wp_q, pf_wp_d;
  logic [PF_AW-1:0]       pf_rp_q, pf_rp_d;
  logic [WIDTH-1:0]       pf_mem_q [PF_DEPTH];
  logic [WIDTH-1:0]       pf_mem_d [PF_DEPTH];
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [WIDTH-1:0]       rdata_q [RD_LAT];

  logic                   rd_ok;
  logic                   wr_ok;
  logic                   mem_we;
  logic                   ram_rd;
  logic                   land;
  int                     inflight;

  function automatic logic [DEPTH_NBITS-1:0] ram_inc(input logic [DEPTH_NBITS-1:0] p);
    return (p == RAM_LAST) ? '0 : p + DEPTH_NBITS'(1);
  endfunction

  function automatic logic [PF_AW-1:0] pf_inc(input logic [PF_AW-1:0] p);
    return (p == PF_LAST) ? '0 : p + PF_AW'(1);
  endfunction

  assign empty     = (pf_cnt_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign afull     = (count_q >= AF_C);
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign dout      = empty ? '0 : pf_mem_q[pf_rp_q];
  assign land      = vld_q[RD_LAT-1];

  always_comb begin
    rd_ok  = rd & ~empty;
    wr_ok  = wr & (~full | rd_ok);
    mem_we = wr_ok & ~flush;
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight += int'(vld_q[i]);
    // The same-cycle pop frees a slot, so it is credited before issuing a new read.
    ram_rd = (ram_cnt_q != '0) &&
             ((int'(pf_cnt_q) + inflight - int'(rd_ok)) < PF_DEPTH) && !flush;
  end

  always_comb begin
    count_d   = count_q;
    ram_cnt_d = ram_cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    vld_d     = vld_q;
    pf_cnt_d  = pf_cnt_q;
    pf_wp_d   = pf_wp_q;
    pf_rp_d   = pf_rp_q;
    pf_mem_d  = pf_mem_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;

    if (flush) begin
      count_d   = '0;
      ram_cnt_d = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      vld_d     = '0;
      pf_cnt_d  = '0;
      pf_wp_d   = '0;
      pf_rp_d   = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      case ({wr_ok, ram_rd})
        2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
        2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
        default: ram_cnt_d = ram_cnt_q;
      endcase

      if (wr_ok)  wptr_d = ram_inc(wptr_q);
      if (ram_rd) rptr_d = ram_inc(rptr_q);

      vld_d[0] = ram_rd;
      for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];

      if (land) begin
        pf_mem_d[pf_wp_q] = rdata_q[RD_LAT-1];
        pf_wp_d           = pf_inc(pf_wp_q);
      end
      if (rd_ok) pf_rp_d = pf_inc(pf_rp_q);

      case ({land, rd_ok})
        2'b10:   pf_cnt_d = pf_cnt_q + PF_CW'(1);
        2'b01:   pf_cnt_d = pf_cnt_q - PF_CW'(1);
        default: pf_cnt_d = pf_cnt_q;
      endcase

      if (wr & ~wr_ok) ovf_d = 1'b1;
      if (rd & empty)  unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      ram_cnt_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      vld_q     <= '0;
      pf_cnt_q  <= '0;
      pf_wp_q   <= '0;
      pf_rp_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      for (int i = 0; i < PF_DEPTH; i++) pf_mem_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      ram_cnt_q <= ram_cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      vld_q     <= vld_d;
      pf_cnt_q  <= pf_cnt_d;
      pf_wp_q   <= pf_wp_d;
      pf_rp_q   <= pf_rp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      for (int i = 0; i < PF_DEPTH; i++) pf_mem_q[i] <= pf_mem_d[i];
    end
  end

  // Storage and read pipeline carry no reset; validity is tracked by vld_q alone.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= din;
    if (ram_rd) rdata_q[0] <= mem[rptr_q];
    for (int i = 1; i < RD_LAT; i++) rdata_q[i] <= rdata_q[i-1];
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(land && !rd_ok && (pf_cnt_q == PF_FULL)));
    end
  end
`endif

endmodule

// File: tb/tb_sfifo_ram_pf_gen.sv
// Self-checking bench for sfifo_ram_pf_gen: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_sfifo_ram_pf_gen;

  localparam int W   = 16;
  localparam int DNB = 4;
  localparam int D   = 1 << DNB;
  localparam int RL  = 3;
  localparam int PFD = RL + 1;
  localparam int AF  = 12;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic [W-1:0]   din;
  logic           wr;
  logic           rd;
  logic [W-1:0]   dout;
  logic           empty;
  logic           full;
  logic           afull;
  logic [DNB:0]   count;
  logic           overflow;
  logic           underflow;

  logic [W-1:0]   exp_q[$];
  bit             m_ovf;
  bit             m_unf;
  bit             last_wr_ok;
  int             checks;
  int             errors;

  sfifo_ram_pf_gen #(
    .WIDTH(W), .DEPTH_NBITS(DNB), .DEPTH(D), .RD_LAT(RL), .PF_DEPTH(PFD), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .wr(wr), .rd(rd),
    .dout(dout), .empty(empty), .full(full), .afull(afull), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; applies one cycle of stimulus, updates the model, returns at the next negedge.
  task automatic drive(input logic w, input logic r, input logic [W-1:0] d);
    bit rd_ok_m;
    bit wr_ok_m;
    rd_ok_m = r && !empty;
    wr_ok_m = w && ((exp_q.size() < D) || rd_ok_m);
    if (w && !wr_ok_m) m_ovf = 1'b1;
    if (r && empty)    m_unf = 1'b1;
    if (rd_ok_m && exp_q.size() > 0) void'(exp_q.pop_front());
    if (wr_ok_m) exp_q.push_back(d);
    last_wr_ok = wr_ok_m;
    wr = w; rd = r; din = d;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic do_flush(input logic w, input logic r);
    flush = 1'b1; wr = w; rd = r; din = W'($urandom);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; wr = 1'b0; rd = 1'b0;
    exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)   begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (afull !== 1'b0)  begin errors++; $display("FAIL reset_afull got=%b exp=0", afull); end
    checks++; if (count !== '0)    begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got=%b exp=0", underflow); end
    checks++; if (dout !== '0)     begin errors++; $display("FAIL reset_dout got=%0h exp=0", dout); end
  endtask

  task automatic test_latency();
    drive(1'b1, 1'b0, 16'h00A5);
    checks++; if (count !== 1) begin errors++; $display("FAIL lat_count got=%0d exp=1", count); end
    for (int c = 1; c < RL + 2; c++) begin
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lat_early_empty cyc=%0d got=%b exp=1", c, empty); end
      drive(1'b0, 1'b0, '0);
    end
    checks++; if (empty !== 1'b0)  begin errors++; $display("FAIL lat_empty got=%b exp=0", empty); end
    checks++; if (dout !== 16'hA5) begin errors++; $display("FAIL lat_dout got=%0h exp=a5", dout); end
    drive(1'b0, 1'b1, '0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lat_pop_empty got=%b exp=1", empty); end
    checks++; if (count !== 0)    begin errors++; $display("FAIL lat_pop_count got=%0d exp=0", count); end
  endtask

  task automatic test_stream();
    int wr_n = 0;
    int nxt  = 1;
    int cyc  = 0;
    bit seen = 1'b0;
    logic r;
    while ((wr_n < 200 || nxt <= 200) && cyc < 600) begin
      if (seen && nxt <= 200) begin
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL stream_bubble cyc=%0d got=%b exp=0", cyc, empty); end
      end
      r = 1'b0;
      if (!empty && nxt <= 200) begin
        seen = 1'b1;
        checks++; if (dout !== W'(nxt)) begin errors++; $display("FAIL stream_dout got=%0d exp=%0d", dout, nxt); end
        r = 1'b1;
        nxt++;
      end
      drive(wr_n < 200, r, W'(wr_n + 1));
      if (wr_n < 200) wr_n++;
      cyc++;
    end
    checks++; if (nxt != 201)  begin errors++; $display("FAIL stream_total got=%0d exp=201", nxt); end
    checks++; if (count !== 0) begin errors++; $display("FAIL stream_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL stream_flags got=%b%b exp=00", overflow, underflow);
    end
  endtask

  task automatic test_fill();
    int guard = 0;
    for (int i = 1; i <= D; i++) begin
      drive(1'b1, 1'b0, W'($urandom));
      checks++; if (count !== i) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", count, i); end
      checks++; if (afull !== (i >= AF)) begin errors++; $display("FAIL fill_afull n=%0d got=%b exp=%b", i, afull, i >= AF); end
      checks++; if (full !== (i == D))   begin errors++; $display("FAIL fill_full n=%0d got=%b exp=%b", i, full, i == D); end
    end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b exp=0", empty); end
    checks++; if (dout !== exp_q[0]) begin errors++; $display("FAIL fill_head got=%0h exp=%0h", dout, exp_q[0]); end
    drive(1'b1, 1'b1, W'($urandom));
    checks++; if (count !== D)       begin errors++; $display("FAIL fill_wrrd_count got=%0d exp=%0d", count, D); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_wrrd_ovf got=%b exp=0", overflow); end
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fill_wrrd_full got=%b exp=1", full); end
    drive(1'b1, 1'b0, W'($urandom));
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_drop_ovf got=%b exp=1", overflow); end
    checks++; if (count !== D)       begin errors++; $display("FAIL fill_drop_count got=%0d exp=%0d", count, D); end
    while (exp_q.size() > 0 && guard < 200) begin
      if (!empty) begin
        checks++; if (dout !== exp_q[0]) begin errors++; $display("FAIL fill_drain got=%0h exp=%0h", dout, exp_q[0]); end
      end
      drive(1'b0, !empty, '0);
      guard++;
    end
    checks++; if (count !== 0)        begin errors++; $display("FAIL fill_drain_count got=%0d exp=0", count); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL fill_unf got=%b exp=0", underflow); end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int cyc    = 0;
    logic w, r;
    do_flush(1'b0, 1'b0);
    while ((pushed < 3 * D || exp_q.size() > 0) && cyc < 3000) begin
      checks++; if (count !== exp_q.size()) begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", count, exp_q.size()); end
      checks++; if (count > D) begin errors++; $display("FAIL wrap_count_max got=%0d exp<=%0d", count, D); end
      checks++; if (full !== (exp_q.size() == D)) begin errors++; $display("FAIL wrap_full got=%b", full); end
      checks++; if (afull !== (exp_q.size() >= AF)) begin errors++; $display("FAIL wrap_afull got=%b", afull); end
      checks++; if (overflow !== m_ovf || underflow !== m_unf) begin
        errors++; $display("FAIL wrap_flags got=%b%b exp=%b%b", overflow, underflow, m_ovf, m_unf);
      end
      if (!empty) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_phantom got=%0h exp=none", dout); end
        else if (dout !== exp_q[0]) begin errors++; $display("FAIL wrap_dout got=%0h exp=%0h", dout, exp_q[0]); end
      end
      w = (pushed < 3 * D) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      drive(w, r, W'($urandom));
      if (last_wr_ok) pushed++;
      cyc++;
    end
    checks++; if (pushed < 3 * D || exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_timeout pushed=%0d left=%0d exp=%0d/0", pushed, exp_q.size(), 3 * D);
    end
  endtask

  task automatic test_underflow_flush();
    int guard = 0;
    do_flush(1'b0, 1'b0);
    drive(1'b0, 1'b1, '0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", underflow); end
    checks++; if (count !== 0)        begin errors++; $display("FAIL unf_count got=%0d exp=0", count); end
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, W'(16'h1000 + i));
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, '0);
    do_flush(1'b1, 1'b1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", empty); end
    checks++; if (count !== 0)    begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL flush_flags got=%b%b exp=00", overflow, underflow);
    end
    for (int c = 0; c < 12; c++) begin
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_stale cyc=%0d dout=%0h exp=empty", c, dout); end
      drive(1'b0, 1'b0, '0);
    end
    drive(1'b1, 1'b0, 16'h0077);
    while (empty && guard < 20) begin drive(1'b0, 1'b0, '0); guard++; end
    checks++; if (dout !== 16'h0077 || empty !== 1'b0) begin
      errors++; $display("FAIL flush_next got=%0h empty=%b exp=77", dout, empty);
    end
    drive(1'b0, 1'b1, '0);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, W'($urandom));
    checks++; if (count !== 9) begin errors++; $display("FAIL rmid_count_pre got=%0d exp=9", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got=%b exp=1", empty); end
    checks++; if (count !== 0)    begin errors++; $display("FAIL rmid_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0 || afull !== 1'b0) begin errors++; $display("FAIL rmid_full got=%b%b exp=00", full, afull); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rmid_flags got=%b%b exp=00", overflow, underflow); end
    checks++; if (dout !== '0)    begin errors++; $display("FAIL rmid_dout got=%0h exp=0", dout); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h003C);
    while (empty && guard < 20) begin drive(1'b0, 1'b0, '0); guard++; end
    checks++; if (dout !== 16'h003C || empty !== 1'b0) begin
      errors++; $display("FAIL rmid_first got=%0h empty=%b exp=3c", dout, empty);
    end
    checks++; if (count !== 1) begin errors++; $display("FAIL rmid_post_count got=%0d exp=1", count); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    m_ovf = 1'b0; m_unf = 1'b0; last_wr_ok = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_stream();
    test_fill();
    test_wrap();
    test_underflow_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
